// File: rtl/pwm_demod.sv
// PWM demodulator: measures high time and period of a synchronized PWM line
// between consecutive rising edges, recovers the duty value and detects a stuck line.
module pwm_demod #(
   parameter int R   = 6,
   parameter int CW  = 16,
   parameter int TMO = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          pwm_in,
   output logic [CW-1:0] high_cnt,
   output logic [CW-1:0] period_cnt,
   output logic [R-1:0]  duty,
   output logic          valid,
   output logic          stuck,
   output logic          per_err
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [CW-1:0] PER   = CW'(2 ** R);
   localparam logic [CW-1:0] TMO_C = CW'(TMO);
   localparam logic [CW-1:0] CMAX  = '1;

   state_t        state, state_nx;
   logic          sync1, s, p;
   logic          rise, fall, timeout, close;
   logic [CW-1:0] hc, pc, tc;
   logic [CW-1:0] hc_nx, pc_nx, tc_nx;
   logic [R-1:0]  duty_w;
   logic [CW:0]   hc2;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CMAX) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         p     <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         s     <= sync1;
         p     <= s;
      end
   end

   assign rise    = s & ~p;
   assign fall    = ~s & p;
   // An edge in the same cycle always beats the timeout.
   assign timeout = en && !stuck && (tc == TMO_C) && !rise && !fall;
   assign close   = en && (state == LOW) && rise;

   always_comb begin
      state_nx = state;
      hc_nx    = hc;
      pc_nx    = pc;
      tc_nx    = (rise || fall) ? '0 : sat_inc(tc);
      if (!en) begin
         state_nx = IDLE;
         hc_nx    = '0;
         pc_nx    = '0;
         tc_nx    = '0;
      end else if (timeout) begin
         state_nx = IDLE;
         hc_nx    = '0;
         pc_nx    = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_nx = HIGH;
                  hc_nx    = CW'(1);
                  pc_nx    = CW'(1);
               end
            end
            HIGH: begin
               pc_nx = sat_inc(pc);
               if (fall) state_nx = LOW;
               else if (s) hc_nx = sat_inc(hc);
            end
            LOW: begin
               if (rise) begin
                  state_nx = HIGH;
                  hc_nx    = CW'(1);
                  pc_nx    = CW'(1);
               end else begin
                  pc_nx = sat_inc(pc);
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hc    <= '0;
         pc    <= '0;
         tc    <= '0;
      end else begin
         state <= state_nx;
         hc    <= hc_nx;
         pc    <= pc_nx;
         tc    <= tc_nx;
      end
   end

   // Exact duty for a nominal period, otherwise a majority decision.
   assign hc2 = {hc, 1'b0};
   always_comb begin
      duty_w = '0;
      if (pc == PER && hc < PER) duty_w = hc[R-1:0];
      else if (hc2 >= {1'b0, pc}) duty_w = '1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_cnt   <= '0;
         period_cnt <= '0;
         duty       <= '0;
         valid      <= 1'b0;
         stuck      <= 1'b0;
         per_err    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (en) begin
            if (close) begin
               high_cnt   <= hc;
               period_cnt <= pc;
               duty       <= duty_w;
               per_err    <= (pc != PER);
               valid      <= 1'b1;
            end else if (timeout) begin
               high_cnt   <= '0;
               period_cnt <= '0;
               duty       <= s ? '1 : '0;
               per_err    <= 1'b1;
               valid      <= 1'b1;
               stuck      <= 1'b1;
            end
            if (rise || fall) stuck <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_demod.sv
// Self-checking bench for pwm_demod: PWM windows are generated as (high, period)
// pairs and every valid strobe is compared with the duty rules computed from them.
module tb_pwm_demod;

   localparam int R   = 6;
   localparam int CW  = 16;
   localparam int TMO = 256;
   localparam int NOM = 2 ** R;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          pwm_in = 1'b0;
   logic [CW-1:0] high_cnt, period_cnt;
   logic [R-1:0]  duty;
   logic          valid, stuck, per_err;

   typedef struct {int h; int p;} win_t;
   typedef struct {int hc; int pc; int duty; int per_err; int stuck; int cyc;} rec_t;

   win_t win_q[$];
   rec_t obs_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   pwm_demod #(.R(R), .CW(CW), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
      .high_cnt(high_cnt), .period_cnt(period_cnt), .duty(duty),
      .valid(valid), .stuck(stuck), .per_err(per_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk)
      if (valid)
         obs_q.push_back('{int'(high_cnt), int'(period_cnt), int'(duty),
                           int'(per_err), int'(stuck), cyc});

   function automatic int exp_duty(input int h, input int p);
      if (p == NOM && h < NOM) return h;
      return (2 * h >= p) ? NOM - 1 : 0;
   endfunction

   task automatic drive_level(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive every queued window, then a closing rise so the last window completes.
   task automatic drive_windows();
      foreach (win_q[i]) begin
         drive_level(1'b1, win_q[i].h);
         drive_level(1'b0, win_q[i].p - win_q[i].h);
      end
      drive_level(1'b1, 6);
   endtask

   task automatic restart();
      en = 1'b0;
      drive_level(1'b0, 5);
      en = 1'b1;
      obs_q.delete();
      win_q.delete();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({high_cnt, period_cnt, duty, valid, stuck, per_err} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got hc=%0d pc=%0d duty=%0d v=%b st=%b pe=%b, need all 0",
                  high_cnt, period_cnt, duty, valid, stuck, per_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      restart();
      repeat (4) win_q.push_back('{40, 64});
      drive_windows();
      checks++;
      if (obs_q.size() != win_q.size()) begin
         errors++;
         $display("[TB] FAIL basic_count: got %0d valids, need %0d", obs_q.size(), win_q.size());
      end
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i].hc != 40 || obs_q[i].pc != 64 || obs_q[i].duty != 40 || obs_q[i].per_err != 0) begin
            errors++;
            $display("[TB] FAIL basic_win%0d: got hc=%0d pc=%0d duty=%0d pe=%0d, need 40/64/40/0",
                     i, obs_q[i].hc, obs_q[i].pc, obs_q[i].duty, obs_q[i].per_err);
         end
         if (i > 0) begin
            checks++;
            if (obs_q[i].cyc - obs_q[i-1].cyc != 64) begin
               errors++;
               $display("[TB] FAIL basic_interval%0d: got %0d clocks, need 64",
                        i, obs_q[i].cyc - obs_q[i-1].cyc);
            end
         end
      end
   endtask

   task automatic test_sweep_and_random();
      restart();
      win_q.push_back('{63, 64});
      win_q.push_back('{1, 64});
      win_q.push_back('{32, 64});
      win_q.push_back('{50, 100});
      win_q.push_back('{49, 100});
      win_q.push_back('{20, 80});
      repeat (16) win_q.push_back('{int'($urandom_range(1, 63)), 64});
      repeat (10) begin
         int p;
         p = int'($urandom_range(2, 150));
         win_q.push_back('{int'($urandom_range(1, p - 1)), p});
      end
      drive_windows();
      checks++;
      if (obs_q.size() != win_q.size()) begin
         errors++;
         $display("[TB] FAIL sweep_count: got %0d valids, need %0d", obs_q.size(), win_q.size());
      end
      foreach (obs_q[i]) begin
         int eh, ep, ed, ee;
         if (i >= win_q.size()) break;
         eh = win_q[i].h;
         ep = win_q[i].p;
         ed = exp_duty(eh, ep);
         ee = (ep != NOM) ? 1 : 0;
         checks++;
         if (obs_q[i].hc != eh || obs_q[i].pc != ep || obs_q[i].duty != ed || obs_q[i].per_err != ee) begin
            errors++;
            $display("[TB] FAIL sweep_win%0d: got hc=%0d pc=%0d duty=%0d pe=%0d, need %0d/%0d/%0d/%0d",
                     i, obs_q[i].hc, obs_q[i].pc, obs_q[i].duty, obs_q[i].per_err, eh, ep, ed, ee);
         end
      end
   endtask

   task automatic test_stuck_low();
      int t0;
      restart();
      t0 = cyc;
      drive_level(1'b0, 300);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL stuck_low_count: got %0d valids, need 1", obs_q.size());
      end else begin
         checks++;
         if (obs_q[0].hc != 0 || obs_q[0].pc != 0 || obs_q[0].duty != 0 || obs_q[0].stuck != 1) begin
            errors++;
            $display("[TB] FAIL stuck_low_values: got hc=%0d pc=%0d duty=%0d st=%0d, need 0/0/0/1",
                     obs_q[0].hc, obs_q[0].pc, obs_q[0].duty, obs_q[0].stuck);
         end
         checks++;
         if (obs_q[0].cyc - t0 < TMO || obs_q[0].cyc - t0 > TMO + 3) begin
            errors++;
            $display("[TB] FAIL stuck_low_time: got %0d clocks, need %0d..%0d",
                     obs_q[0].cyc - t0, TMO, TMO + 3);
         end
      end
      drive_level(1'b1, 6);
      checks++;
      if (stuck !== 1'b0 || obs_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL stuck_clear: got stuck=%b valids=%0d, need 0/1", stuck, obs_q.size());
      end
   endtask

   task automatic test_stuck_high_and_per_err();
      restart();
      drive_level(1'b1, 300);
      checks++;
      if (obs_q.size() != 1 || stuck !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stuck_high_count: got %0d valids stuck=%b, need 1/1", obs_q.size(), stuck);
      end else begin
         checks++;
         if (obs_q[0].hc != 0 || obs_q[0].pc != 0 || obs_q[0].duty != NOM - 1) begin
            errors++;
            $display("[TB] FAIL stuck_high_values: got hc=%0d pc=%0d duty=%0d, need 0/0/%0d",
                     obs_q[0].hc, obs_q[0].pc, obs_q[0].duty, NOM - 1);
         end
      end
      drive_level(1'b0, 5);
      obs_q.delete();
      repeat (3) win_q.push_back('{20, 80});
      drive_windows();
      checks++;
      if (obs_q.size() != 3) begin
         errors++;
         $display("[TB] FAIL per80_count: got %0d valids, need 3", obs_q.size());
      end
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i].hc != 20 || obs_q[i].pc != 80 || obs_q[i].duty != 0 || obs_q[i].per_err != 1) begin
            errors++;
            $display("[TB] FAIL per80_win%0d: got hc=%0d pc=%0d duty=%0d pe=%0d, need 20/80/0/1",
                     i, obs_q[i].hc, obs_q[i].pc, obs_q[i].duty, obs_q[i].per_err);
         end
      end
   endtask

   task automatic test_reset_midwindow();
      restart();
      drive_level(1'b1, 30);
      drive_level(1'b0, 34);
      drive_level(1'b1, 20);
      rst_n = 1'b0;
      pwm_in = 1'b0;
      #1;
      checks++;
      if ({high_cnt, period_cnt, duty, valid, stuck, per_err} !== '0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got hc=%0d pc=%0d duty=%0d v=%b st=%b pe=%b, need all 0",
                  high_cnt, period_cnt, duty, valid, stuck, per_err);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      en = 1'b1;
      drive_level(1'b0, 5);
      en = 1'b0;
      drive_level(1'b0, 5);
      en = 1'b1;
      obs_q.delete();
      drive_level(1'b0, 5);
      drive_level(1'b1, 25);
      drive_level(1'b0, 39);
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL midreset_early_valid: got %0d valids, need 0", obs_q.size());
      end
      drive_level(1'b1, 50);
      drive_level(1'b0, 14);
      drive_level(1'b1, 6);
      checks++;
      if (obs_q.size() != 2) begin
         errors++;
         $display("[TB] FAIL midreset_count: got %0d valids, need 2", obs_q.size());
      end else begin
         checks++;
         if (obs_q[0].hc != 25 || obs_q[0].pc != 64 || obs_q[0].duty != 25 ||
             obs_q[1].hc != 50 || obs_q[1].pc != 64 || obs_q[1].duty != 50) begin
            errors++;
            $display("[TB] FAIL midreset_values: got %0d/%0d/%0d then %0d/%0d/%0d, need 25/64/25 then 50/64/50",
                     obs_q[0].hc, obs_q[0].pc, obs_q[0].duty, obs_q[1].hc, obs_q[1].pc, obs_q[1].duty);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep_and_random();
      test_stuck_low();
      test_stuck_high_and_per_err();
      test_reset_midwindow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
